// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG request engine: opcodes, control byte,
// FSM state encodings and a chunk-count helper.
package ipg_pkg;

  // Request / reply opcodes (top two header bits)
  localparam logic [1:0] OP_C_READ  = 2'b00;
  localparam logic [1:0] OP_C_WRITE = 2'b01;
  localparam logic [1:0] OP_D_READ  = 2'b10;
  localparam logic [1:0] OP_D_WRITE = 2'b11;

  // Tag carried in the low byte of every memQ chunk
  localparam logic [7:0] CTRL_BYTE = 8'h1c;

  // Engine FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_BUILD = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  // Number of chunks needed to carry 'bits' reply bits on a dw-wide chunk bus
  function automatic int unsigned chunks(input int unsigned bits, input int unsigned dw);
    return (bits + dw - 9) / (dw - 8);
  endfunction

endpackage

// File: rtl/ipg_job_fifo.sv
// First-word-fall-through job FIFO.
// Ports: clk, reset (async active-low), push/wdata write side, pop/rdata_c read
// side (rdata_c shows the head while !empty_c), empty_c/full_c flags, level count.
// A push while full is accepted only together with a pop.
module ipg_job_fifo #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     empty_c,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (level == '0);
  assign full_c  = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign rdata_c = mem[rd_ptr];

  // Pointers and occupancy; reset flushes the queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ipg_req_engine.sv
// IPG request engine: queues request frames, decodes c_read / c_write, builds
// the memory reply (or write ack) and streams it to memQ as tagged chunks.
// Ports: clk, reset (async active-low); rx_ipg_data/rx_len/rreq_valid frame input;
// memq_full backpressure; ipg_reply_chunk/memq_write/chunk_last chunk output;
// busy, drop_err, op_err status; jobq_level FIFO occupancy. All outputs registered.
module ipg_req_engine
  import ipg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned HDR_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH  = 40,
  parameter int unsigned PAYLOAD_LEN = 512,
  parameter int unsigned JOBQ_DEPTH  = 8,
  parameter int unsigned LEN_WIDTH   = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         rx_ipg_data,
  input  logic [LEN_WIDTH-1:0]          rx_len,
  input  logic                          rreq_valid,
  input  logic                          memq_full,
  output logic [DATA_WIDTH-1:0]         ipg_reply_chunk,
  output logic                          memq_write,
  output logic                          chunk_last,
  output logic                          busy,
  output logic                          drop_err,
  output logic                          op_err,
  output logic [$clog2(JOBQ_DEPTH):0]   jobq_level
);

  localparam int unsigned LVL_W   = $clog2(JOBQ_DEPTH) + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + LEN_WIDTH;
  localparam int unsigned CHUNK_W = DATA_WIDTH - 8;
  localparam int unsigned SR_W    = PAYLOAD_LEN + HDR_WIDTH;
  localparam int unsigned ACK_W   = HDR_WIDTH + ADDR_WIDTH;
  localparam int unsigned BEATS   = PAYLOAD_LEN / DATA_WIDTH;
  localparam int unsigned BEAT_W  = $clog2(BEATS + 1);
  localparam int unsigned REM_W   = $clog2(SR_W + 1);
  localparam int unsigned WORDS   = PAYLOAD_LEN / 64;

  logic [ENTRY_W-1:0]    head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push_c;
  logic                  pop_c;
  logic [1:0]            op_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  unused_head_c;

  logic [1:0]            state,    state_d;
  logic                  is_write, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [BEAT_W-1:0]     beat_cnt, beat_cnt_d;
  logic [SR_W-1:0]       sr,       sr_d;
  logic [REM_W-1:0]      rem,      rem_d;
  logic [DATA_WIDTH-1:0] chunk_d;
  logic                  memq_write_d, chunk_last_d, op_err_d, drop_d, busy_d;
  logic [LVL_W-1:0]      level_d;
  logic [63:0]           addr_word_c;

  // Frame acceptance: empty frames ignored, frames arriving while full are lost
  assign push_c = rreq_valid && (rx_len != '0) && !fifo_full;
  assign drop_d = rreq_valid && (rx_len != '0) && fifo_full;

  ipg_job_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (JOBQ_DEPTH)
  ) u_job_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   ({rx_ipg_data, rx_len}),
    .rdata_c (head),
    .empty_c (fifo_empty),
    .full_c  (fifo_full),
    .level   (jobq_level)
  );

  // Head decode; low header bits, trailing data bits and frame length are not needed
  assign op_c          = head[ENTRY_W-1 -: 2];
  assign addr_c        = head[ENTRY_W-1-HDR_WIDTH -: ADDR_WIDTH];
  assign unused_head_c = ^{head[ENTRY_W-3 -: HDR_WIDTH-2],
                           head[ENTRY_W-1-HDR_WIDTH-ADDR_WIDTH:0]};
  assign addr_word_c   = 64'(addr_q);
  assign level_d       = jobq_level + LVL_W'(push_c) - LVL_W'(pop_c);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    is_write_d   = is_write;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt;
    sr_d         = sr;
    rem_d        = rem;
    chunk_d      = ipg_reply_chunk;
    memq_write_d = 1'b0;
    chunk_last_d = 1'b0;
    op_err_d     = 1'b0;
    pop_c        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop_c  = 1'b1;
          addr_d = addr_c;
          case (op_c)
            OP_C_READ: begin
              is_write_d = 1'b0;
              state_d    = S_BUILD;
            end
            OP_C_WRITE: begin
              is_write_d = 1'b1;
              beat_cnt_d = '0;
              state_d    = S_WDATA;
            end
            OP_D_READ, OP_D_WRITE: op_err_d = 1'b1;
            default: op_err_d = 1'b1;
          endcase
        end
      end
      // Write payload beats are consumed and discarded; waits indefinitely for data
      S_WDATA: begin
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          beat_cnt_d = beat_cnt + 1'b1;
          if (beat_cnt == BEAT_W'(BEATS - 1)) state_d = S_BUILD;
        end
      end
      // Load the reply MSB-first; unused tail of an ack is pre-filled with ones
      S_BUILD: begin
        if (is_write) begin
          sr_d  = SR_W'({OP_D_WRITE, (HDR_WIDTH-2)'(beat_cnt), addr_q,
                         {(SR_W-ACK_W){1'b1}}});
          rem_d = REM_W'(ACK_W);
        end else begin
          sr_d  = SR_W'({OP_D_READ, (HDR_WIDTH-2)'(PAYLOAD_LEN), {WORDS{addr_word_c}}});
          rem_d = REM_W'(SR_W);
        end
        state_d = S_EMIT;
      end
      // Shift ones in from the bottom so the final partial chunk is 1-padded
      S_EMIT: begin
        if (!memq_full) begin
          memq_write_d = 1'b1;
          chunk_d      = {sr[SR_W-1 -: CHUNK_W], CTRL_BYTE};
          sr_d         = {sr[SR_W-CHUNK_W-1:0], {CHUNK_W{1'b1}}};
          rem_d        = (rem > REM_W'(CHUNK_W)) ? rem - REM_W'(CHUNK_W) : '0;
          if (rem <= REM_W'(CHUNK_W)) begin
            chunk_last_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      is_write        <= 1'b0;
      addr_q          <= '0;
      beat_cnt        <= '0;
      sr              <= '0;
      rem             <= '0;
      ipg_reply_chunk <= '1;
      memq_write      <= 1'b0;
      chunk_last      <= 1'b0;
      busy            <= 1'b0;
      drop_err        <= 1'b0;
      op_err          <= 1'b0;
    end else begin
      state           <= state_d;
      is_write        <= is_write_d;
      addr_q          <= addr_d;
      beat_cnt        <= beat_cnt_d;
      sr              <= sr_d;
      rem             <= rem_d;
      ipg_reply_chunk <= chunk_d;
      memq_write      <= memq_write_d;
      chunk_last      <= chunk_last_d;
      busy            <= busy_d;
      drop_err        <= drop_d;
      op_err          <= op_err_d;
    end
  end

endmodule

// File: tb/tb_ipg_req_engine.sv
// Self-checking bench for ipg_req_engine: directed steps with random addresses,
// expected chunks built from a bit-level reply model.
module tb_ipg_req_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] rx_ipg_data = '0;
  logic [5:0]  rx_len = '0;
  logic        rreq_valid = 1'b0;
  logic        memq_full = 1'b0;
  logic [63:0] ipg_reply_chunk;
  logic        memq_write, chunk_last, busy, drop_err, op_err;
  logic [3:0]  jobq_level;

  always #5 clk = ~clk;

  ipg_req_engine #(
    .DATA_WIDTH(64), .HDR_WIDTH(16), .ADDR_WIDTH(40),
    .PAYLOAD_LEN(512), .JOBQ_DEPTH(8), .LEN_WIDTH(6)
  ) dut (
    .clk(clk), .reset(reset), .rx_ipg_data(rx_ipg_data), .rx_len(rx_len),
    .rreq_valid(rreq_valid), .memq_full(memq_full),
    .ipg_reply_chunk(ipg_reply_chunk), .memq_write(memq_write),
    .chunk_last(chunk_last), .busy(busy), .drop_err(drop_err),
    .op_err(op_err), .jobq_level(jobq_level)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned drive_cyc = 0;
  int unsigned op_err_cnt = 0;
  int unsigned drop_cnt = 0;

  logic [63:0] got_q[$];
  bit          got_last_q[$];
  int unsigned got_cyc_q[$];
  logic [63:0] exp_q[$];
  bit          exp_last_q[$];

  // Output monitor, sampled 1ns after the rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      if (memq_write) begin
        got_q.push_back(ipg_reply_chunk);
        got_last_q.push_back(chunk_last);
        got_cyc_q.push_back(cyc);
      end
      if (op_err)   op_err_cnt++;
      if (drop_err) drop_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read reply: header {10, 512} then 8 words of zero-extended address,
  // cut into 56-bit slices, last slice padded with ones
  function automatic void push_read_exp(input logic [39:0] a);
    bit          bits[$];
    logic [15:0] hdr;
    logic [63:0] word;
    logic [55:0] pay;
    hdr  = 16'h8000 + 16'd512;
    word = {24'h0, a};
    for (int i = 15; i >= 0; i--) bits.push_back(hdr[i]);
    for (int w = 0; w < 8; w++)
      for (int i = 63; i >= 0; i--) bits.push_back(word[i]);
    while (bits.size() > 0) begin
      for (int j = 55; j >= 0; j--) pay[j] = (bits.size() > 0) ? bits.pop_front() : 1'b1;
      exp_q.push_back({pay, 8'h1c});
      exp_last_q.push_back(bits.size() == 0);
    end
  endfunction

  function automatic void push_write_exp(input logic [39:0] a, input int unsigned beats);
    exp_q.push_back({16'hC000 + 16'(beats), a, 8'h1c});
    exp_last_q.push_back(1'b1);
  endfunction

  function automatic logic [39:0] rand_addr();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic drive(input logic [63:0] d, input logic [5:0] len);
    @(negedge clk);
    rx_ipg_data = d;
    rx_len      = len;
    rreq_valid  = 1'b1;
    drive_cyc   = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    rreq_valid = 1'b0;
    rx_len     = '0;
  endtask

  task automatic wait_chunks(input int unsigned n, input int unsigned budget);
    for (int i = 0; i < int'(budget) && got_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic clear_queues();
    got_q.delete(); got_last_q.delete(); got_cyc_q.delete();
    exp_q.delete(); exp_last_q.delete();
  endtask

  task automatic compare_and_clear(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_chunk%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), 64'(got_last_q[i]), 64'(exp_last_q[i]));
    end
    clear_queues();
  endtask

  initial begin
    logic [39:0] a;
    logic [39:0] addrs[10];
    int unsigned t0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_chunk", ipg_reply_chunk, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_write", 64'(memq_write), 64'(0));
    check("rst_last",  64'(chunk_last), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_drop",  64'(drop_err), 64'(0));
    check("rst_operr", 64'(op_err), 64'(0));
    check("rst_level", 64'(jobq_level), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single c_read, latency and format
    a = 40'h12_3456_789A;
    push_read_exp(a);
    drive({16'h0000, a, 8'h00}, 6'd56);
    t0 = drive_cyc + 1;
    idle();
    wait_chunks(10, 40);
    repeat (5) @(negedge clk);
    if (got_q.size() >= 10) begin
      check("t1_first_lat", 64'(got_cyc_q[0] - t0), 64'd3);
      check("t1_last_lat",  64'(got_cyc_q[9] - t0), 64'd12);
      check("t1_hdr",       64'(got_q[0][63:48]), 64'h8200);
      check("t1_pad",       64'(got_q[9][31:8]), 64'hFF_FFFF);
    end
    compare_and_clear("t1");
    check("t1_idle_busy",  64'(busy), 64'(0));
    check("t1_idle_level", 64'(jobq_level), 64'(0));

    // 2a: c_write with back-to-back beats
    a = rand_addr();
    push_write_exp(a, 8);
    drive({16'h4000, a, 8'h00}, 6'd56);
    for (int b = 0; b < 8; b++) drive({$urandom, $urandom}, 6'd63);
    idle();
    wait_chunks(1, 40);
    repeat (5) @(negedge clk);
    compare_and_clear("t2a");

    // 2b: c_write with gapped beats; engine must wait in the data phase
    a = rand_addr();
    push_write_exp(a, 8);
    drive({16'h4000, a, 8'h00}, 6'd56);
    idle();
    for (int b = 0; b < 8; b++) begin
      if (b == 7) begin
        repeat (6) @(negedge clk);
        check("t2b_hold_nochunk", 64'(got_q.size()), 64'(0));
        check("t2b_hold_busy",    64'(busy), 64'(1));
      end
      drive({$urandom, $urandom}, 6'(1 + $urandom_range(0, 62)));
      idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_chunks(1, 40);
    repeat (5) @(negedge clk);
    compare_and_clear("t2b");

    // 3: alternating backpressure, payload identical to test 1
    a = 40'h12_3456_789A;
    push_read_exp(a);
    drive({16'h0000, a, 8'h00}, 6'd56);
    idle();
    for (int i = 0; i < 80 && got_q.size() < 10; i++) begin
      @(negedge clk);
      memq_full = (i % 2) == 1;
    end
    memq_full = 1'b0;
    repeat (5) @(negedge clk);
    compare_and_clear("t3");

    // 3b: random backpressure, random address
    a = rand_addr();
    push_read_exp(a);
    drive({2'b00, 14'($urandom), a, 8'($urandom)}, 6'd56);
    idle();
    for (int i = 0; i < 120 && got_q.size() < 10; i++) begin
      @(negedge clk);
      memq_full = 1'($urandom_range(0, 1));
    end
    memq_full = 1'b0;
    repeat (5) @(negedge clk);
    compare_and_clear("t3b");

    // 4: overflow with memQ blocked: one job in service plus 8 queued, the 10th dropped
    memq_full = 1'b1;
    drop_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      addrs[i] = rand_addr();
      if (i < 9) push_read_exp(addrs[i]);
      drive({16'h0000, addrs[i], 8'h00}, 6'd56);
    end
    idle();
    repeat (3) @(negedge clk);
    check("t4_level",    64'(jobq_level), 64'd8);
    check("t4_drops",    64'(drop_cnt), 64'd1);
    check("t4_busy",     64'(busy), 64'(1));
    check("t4_nochunks", 64'(got_q.size()), 64'(0));
    memq_full = 1'b0;
    wait_chunks(90, 400);
    repeat (5) @(negedge clk);
    compare_and_clear("t4");
    check("t4_level_end", 64'(jobq_level), 64'(0));

    // 5: bad opcodes raise op_err; empty frames never enqueue
    op_err_cnt = 0;
    drive({16'h8000, rand_addr(), 8'h00}, 6'd56);
    for (int i = 0; i < 3; i++) drive({16'h0000, rand_addr(), 8'h00}, 6'd0);
    idle();
    check("t5_len0_level", 64'(jobq_level), 64'(0));
    repeat (3) @(negedge clk);
    drive({16'hC000, rand_addr(), 8'h00}, 6'd56);
    idle();
    repeat (5) @(negedge clk);
    check("t5_operr_cnt", 64'(op_err_cnt), 64'd2);
    check("t5_nochunks",  64'(got_q.size()), 64'(0));
    check("t5_level",     64'(jobq_level), 64'(0));
    check("t5_busy",      64'(busy), 64'(0));
    clear_queues();

    // 6: asynchronous reset mid-reply, then a clean reply
    a = rand_addr();
    push_read_exp(a);
    drive({16'h0000, a, 8'h00}, 6'd56);
    idle();
    wait_chunks(4, 40);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_write", 64'(memq_write), 64'(0));
    check("t6_rst_last",  64'(chunk_last), 64'(0));
    check("t6_rst_chunk", ipg_reply_chunk, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t6_rst_level", 64'(jobq_level), 64'(0));
    check("t6_rst_busy",  64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_partial_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("t6_partial%0d", i), got_q[i], exp_q[i]);
    clear_queues();
    a = rand_addr();
    push_read_exp(a);
    drive({16'h0000, a, 8'h00}, 6'd56);
    idle();
    wait_chunks(10, 40);
    repeat (5) @(negedge clk);
    compare_and_clear("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
